// File: rtl/vezerles_utemezo_pkg.sv
// Shared state encoding, code-order constants and the index-to-code mapping
// used by the vezerles_utemezo sequencer.
package vezerles_utemezo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  function automatic logic [2:0] seq_code(input logic [2:0] idx, input logic mode);
    return (mode == MODE_GRAY) ? (idx ^ (idx >> 1)) : idx;
  endfunction

endpackage

// File: rtl/vezerles_utemezo_dekoder.sv
// Combinational 3-input / 2-output control decoder (a is the MSB of the code).
module vezerles_dekoder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_q1,
  output logic o_q2
);

  assign o_q1 = (~i_a & ~(i_b & i_c)) | (i_a & i_b);
  assign o_q2 = i_a | (i_b & i_c);

endmodule

// File: rtl/vezerles_utemezo.sv
// Steps the decoder input code through a latched index range, holding each
// code for a programmable number of cycles, with a start/busy/done handshake.
//
//   state | meaning
//   IDLE  | outputs parked at 0, waiting for start
//   RUN   | driving codes; hold counter counts down per code
//   DONE  | one-cycle completion pulse, then back to IDLE
module vezerles_utemezo
  import vezerles_utemezo_pkg::*;
#(
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [2:0]        i_first_code,
  input  logic [2:0]        i_last_code,
  input  logic [HOLD_W-1:0] i_hold_len,
  input  logic              i_mode,
  output logic              o_a,
  output logic              o_b,
  output logic              o_c,
  output logic              o_q1,
  output logic              o_q2,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_q2_count
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_idx;
  logic [2:0]          r_last;
  logic                r_mode;
  logic [HOLD_W-1:0]   r_reload;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [2:0]          r_code;
  logic                r_q1;
  logic                r_q2;
  logic [CNT_W-1:0]    r_q2_count;

  logic                w_load;
  logic                w_step;
  logic                w_hold_dec;
  logic                w_clear;
  logic [2:0]          w_next_idx;
  logic                w_next_mode;
  logic [2:0]          w_next_code;
  logic                w_dec_q1;
  logic                w_dec_q2;
  logic [HOLD_W-1:0]   w_start_reload;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // stop is checked before the hold/step/complete decisions so it always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_hold_dec  = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_stop) begin
          w_clear     = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_hold_cnt != '0) begin
          w_hold_dec = 1'b1;
        end else if (r_idx == r_last) begin
          w_clear     = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The decoder sees the code about to be driven, so q1/q2 land with a,b,c.
  assign w_next_idx     = (r_state == IDLE) ? i_first_code : r_idx + 3'd1;
  assign w_next_mode    = (r_state == IDLE) ? i_mode : r_mode;
  assign w_next_code    = seq_code(w_next_idx, w_next_mode);
  assign w_start_reload = (i_hold_len == '0) ? '0 : i_hold_len - 1'b1;

  vezerles_dekoder u_dekoder (
    .i_a  (w_next_code[2]),
    .i_b  (w_next_code[1]),
    .i_c  (w_next_code[0]),
    .o_q1 (w_dec_q1),
    .o_q2 (w_dec_q2)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx      <= '0;
      r_last     <= '0;
      r_mode     <= MODE_BIN;
      r_reload   <= '0;
      r_hold_cnt <= '0;
      r_code     <= '0;
      r_q1       <= 1'b0;
      r_q2       <= 1'b0;
      r_q2_count <= '0;
    end else begin
      if (w_load) begin
        r_idx      <= i_first_code;
        r_last     <= i_last_code;
        r_mode     <= i_mode;
        r_reload   <= w_start_reload;
        r_hold_cnt <= w_start_reload;
        r_code     <= w_next_code;
        r_q1       <= w_dec_q1;
        r_q2       <= w_dec_q2;
        r_q2_count <= w_dec_q2 ? CNT_W'(1) : '0;
      end else if (w_step) begin
        r_idx      <= w_next_idx;
        r_hold_cnt <= r_reload;
        r_code     <= w_next_code;
        r_q1       <= w_dec_q1;
        r_q2       <= w_dec_q2;
        if (w_dec_q2 && (r_q2_count != '1))
          r_q2_count <= r_q2_count + 1'b1;
      end else if (w_hold_dec) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
      if (w_clear) begin
        r_code     <= '0;
        r_q1       <= 1'b0;
        r_q2       <= 1'b0;
        r_hold_cnt <= '0;
      end
    end
  end

  assign o_a        = r_code[2];
  assign o_b        = r_code[1];
  assign o_c        = r_code[0];
  assign o_q1       = r_q1;
  assign o_q2       = r_q2;
  assign o_busy     = (r_state == RUN);
  assign o_done     = (r_state == DONE);
  assign o_q2_count = r_q2_count;

endmodule

// File: tb/tb_vezerles_utemezo.sv
// Scoreboard bench for vezerles_utemezo: a per-cycle expected output trace is
// built from a reference model at start time and compared cycle by cycle.
module tb_vezerles_utemezo;

  localparam int HOLD_W = 8;
  localparam int CNT_W  = 2;
  localparam int VW     = 7 + CNT_W;

  typedef logic [VW-1:0] exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [2:0]        first_code;
  logic [2:0]        last_code;
  logic [HOLD_W-1:0] hold_len;
  logic              mode;
  logic              a, b, c, q1, q2, busy, done;
  logic [CNT_W-1:0]  q2_count;

  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  vezerles_utemezo #(.HOLD_W(HOLD_W), .CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_stop       (stop),
    .i_first_code (first_code),
    .i_last_code  (last_code),
    .i_hold_len   (hold_len),
    .i_mode       (mode),
    .o_a          (a),
    .o_b          (b),
    .o_c          (c),
    .o_q1         (q1),
    .o_q2         (q2),
    .o_busy       (busy),
    .o_done       (done),
    .o_q2_count   (q2_count)
  );

  function automatic logic [1:0] dec_ref(input logic [2:0] code);
    case (code)
      3'd0, 3'd1, 3'd2: return 2'b10;
      3'd3, 3'd4, 3'd5: return 2'b01;
      default:          return 2'b11;
    endcase
  endfunction

  function automatic exp_t mk(input logic [2:0] code, input logic bsy, input logic dn,
                              input logic [CNT_W-1:0] cnt);
    logic [1:0] q;
    q = bsy ? dec_ref(code) : 2'b00;
    return {(bsy ? code : 3'b000), q, bsy, dn, cnt};
  endfunction

  // Expected trace: every RUN cycle, then done (or abort/reset) and one idle cycle.
  task automatic build(input logic [2:0] f, input logic [2:0] l, input int hold,
                       input logic m, input int cut, input bit cut_rst);
    int               h;
    int               cyc;
    bit               fin;
    bit               last_seen;
    logic [2:0]       idx;
    logic [2:0]       code;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cmax;
    h = (hold == 0) ? 1 : hold;
    idx = f; cnt = '0; cyc = 0; fin = 0; last_seen = 0;
    cmax = '1;
    for (int s = 0; s < 8 && !fin && !last_seen; s++) begin
      code = m ? (idx ^ (idx >> 1)) : idx;
      if (dec_ref(code) & 2'b01) cnt = (cnt == cmax) ? cnt : cnt + 1'b1;
      for (int k = 0; k < h && !fin; k++) begin
        cyc++;
        sb.push_back(mk(code, 1'b1, 1'b0, cnt));
        if (cyc == cut) fin = 1;
      end
      if (idx == l) last_seen = 1;
      idx = idx + 3'd1;
    end
    if (cut > 0) begin
      sb.push_back(mk(3'd0, 1'b0, 1'b0, cut_rst ? '0 : cnt));
      sb.push_back(mk(3'd0, 1'b0, 1'b0, cut_rst ? '0 : cnt));
    end else begin
      sb.push_back(mk(3'd0, 1'b0, 1'b1, cnt));
      sb.push_back(mk(3'd0, 1'b0, 1'b0, cnt));
    end
  endtask

  task automatic run(input string name, input logic [2:0] f, input logic [2:0] l,
                     input int hold, input logic m, input int cut, input bit cut_rst,
                     input int restart_at);
    exp_t e;
    exp_t obs;
    int   cyc;
    build(f, l, hold, m, cut, cut_rst);
    first_code = f; last_code = l; hold_len = HOLD_W'(hold); mode = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_code = ~f; last_code = ~l; hold_len = HOLD_W'(hold + 5); mode = ~m;
    cyc = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = {a, b, c, q1, q2, busy, done, q2_count};
      checks++;
      if (obs !== e)
        $display("FAIL %s cycle %0d: got abc=%b q1q2=%b busy=%b done=%b cnt=%0d, want abc=%b q1q2=%b busy=%b done=%b cnt=%0d",
                 name, cyc, obs[VW-1 -: 3], obs[VW-4 -: 2], obs[CNT_W+1], obs[CNT_W],
                 obs[CNT_W-1:0], e[VW-1 -: 3], e[VW-4 -: 2], e[CNT_W+1], e[CNT_W],
                 e[CNT_W-1:0]);
      else passed++;
      rst   = (cyc == cut) && cut_rst;
      stop  = (cyc == cut) && !cut_rst;
      start = (cyc == restart_at);
      @(posedge clk); #1;
      cyc++;
    end
    rst = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; stop = 1'b1;
    first_code = 3'd5; last_code = 3'd2; hold_len = 8'd2; mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    checks++;
    if ({a, b, c, q1, q2, busy, done, q2_count} !== '0)
      $display("FAIL reset: got %b, want all zero", {a, b, c, q1, q2, busy, done, q2_count});
    else passed++;
    // stop while idle must not disturb anything
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    checks++;
    if ({a, b, c, q1, q2, busy, done, q2_count} !== '0)
      $display("FAIL idle_stop: got %b, want all zero", {a, b, c, q1, q2, busy, done, q2_count});
    else passed++;
  endtask

  task automatic test_binary_full;   run("binary_full", 3'd0, 3'd7, 1, 1'b0, 0, 0, 0); endtask
  task automatic test_gray_full;     run("gray_full",   3'd0, 3'd7, 1, 1'b1, 0, 0, 0); endtask
  task automatic test_wrap_hold;     run("wrap_hold",   3'd6, 3'd1, 3, 1'b0, 0, 0, 0); endtask
  task automatic test_single_hold0;  run("single_h0",   3'd3, 3'd3, 0, 1'b0, 0, 0, 0); endtask
  task automatic test_full_circle;   run("circle_gray", 3'd5, 3'd4, 2, 1'b1, 0, 0, 0); endtask
  task automatic test_abort;         run("abort",       3'd0, 3'd7, 4, 1'b0, 10, 0, 0); endtask
  task automatic test_reset_mid_run; run("rst_mid",     3'd0, 3'd7, 1, 1'b0, 5, 1, 2); endtask
  task automatic test_back_to_back;  run("after_rst",   3'd2, 3'd6, 2, 1'b1, 0, 0, 0); endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    first_code = '0; last_code = '0; hold_len = '0; mode = 1'b0;
    test_reset();
    test_binary_full();
    test_gray_full();
    test_wrap_hold();
    test_single_hold0();
    test_full_circle();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vezerles_utemezo.md
Name: vezerles_utemezo

Overview:
- Synchronous sequencer for the 3-input / 2-output control decoder.
- Steps the decoder input code (a,b,c) through a programmed range, holding each code for a programmable number of cycles, in binary or Gray order.
- Registers the decoder outputs aligned with the code, counts steps that assert q2, and reports completion with a start/busy/done handshake.
- Sits between the test/operator control logic and the combinational decoder.

Parameters:
HOLD_W, 8, width of hold_len and of the internal hold counter
CNT_W, 8, width of q2_count

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active high
start  in  1  one-cycle request; sampled only in IDLE
stop  in  1  abort; sampled only in RUN
first_code  in  3  first sequence index, latched on accepted start
last_code  in  3  final sequence index, latched on accepted start
hold_len  in  HOLD_W  cycles per code, latched on accepted start; 0 is treated as 1
mode  in  1  0 = binary code order, 1 = Gray code order; latched on accepted start
a, b, c  out  1 each  registered decoder input code (a = MSB)
q1, q2  out  1 each  registered decoder outputs for the current a,b,c
busy  out  1  high in RUN
done  out  1  one-cycle pulse on normal completion
q2_count  out  CNT_W  number of sequence steps with q2 = 1; saturating

Behaviour:
- Decoder function, code abc to (q1,q2):
  - 000, 001, 010 → (1,0)
  - 011, 100, 101 → (0,1)
  - 110, 111 → (1,1)
  - Equivalently q1 = (~a & ~(b&c)) | (a&b); q2 = a | (b&c).
- Reset: state IDLE; a=b=c=0; q1=q2=0; busy=0; done=0; q2_count=0; internal index and hold counter 0. Reset overrides all inputs in the same cycle, including mid-RUN.
- States: IDLE, RUN, DONE.
- IDLE:
  - outputs a,b,c,q1,q2 = 0.
  - start=1 → latch first_code, last_code, hold_len, mode; idx=first_code; hold counter = max(hold_len,1)-1; clear q2_count; drive code from idx; go to RUN.
  - First code is visible on a,b,c the cycle after start, with busy=1.
- Code mapping: binary, code = idx; Gray, code = idx ^ (idx >> 1).
- q1/q2: updated on the same edge as a,b,c, computed from the new code. No extra latency.
- RUN:
  - Hold phase: while hold counter > 0, decrement and keep code.
  - Hold counter = 0 and idx == last_code → go to DONE; a,b,c,q1,q2 return to 0.
  - Hold counter = 0, otherwise → idx = idx+1 mod 8 (7 wraps to 0), reload hold counter, drive new code.
- Range rules:
  - The range may wrap: first=6, last=1 gives 6,7,0,1.
  - first == last gives exactly one code.
  - A full-circle run requires last = first−1 mod 8.
- Timing: total RUN cycles = N_codes × max(hold_len,1).
- q2_count:
  - Increments once per code step, on the cycle that code is first driven, if that code's q2 = 1.
  - Saturates at 2^CNT_W−1.
  - Holds its value after completion or abort until the next accepted start.
- stop in RUN: next cycle IDLE, a,b,c,q1,q2 = 0, busy=0, no done pulse. stop takes priority over a step or completion in the same cycle.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Ignored inputs:
  - start is ignored in RUN and DONE.
  - stop is ignored in IDLE and DONE.
  - start in the DONE cycle is lost; requesters wait for IDLE.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - MODE_BIN=1'b0, MODE_GRAY=1'b1
- One natural sub-module: vezerles_dekoder, the purely combinational 3-to-2 decoder above.
  - Instantiated once, fed by the next-code value.
  - Its outputs are registered into q1/q2 and used for the q2_count increment.

Test Plan:
- Binary full run: mode=0, first=0, last=7, hold_len=1, start → a,b,c step 000..111 one per cycle; q1 = 1,1,1,0,0,0,1,1; q2 = 0,0,0,1,1,1,1,1; busy 8 cycles; done pulse on cycle 9; q2_count=5.
- Gray full run: mode=1, first=0, last=7, hold_len=1 → codes 000,001,011,010,110,111,101,100; q2 = 0,0,1,0,1,1,1,1; q2_count=5; done after 8 RUN cycles.
- Wrap range with hold: mode=0, first=6, last=1, hold_len=3 → codes 110,111,000,001, each held 3 cycles; busy 12 cycles; q2_count=2.
- hold_len=0 and single code: first=last=3, hold_len=0 → code 011 for 1 cycle, q1=0, q2=1, q2_count=1, then done pulse.
- Abort: binary 0..7, hold_len=4, stop asserted on RUN cycle 10 → next cycle a,b,c = 000, busy=0, done never pulses, q2_count=0 (codes 000,001,010 only).
- Reset mid-run and start while busy: start pulsed again in RUN has no effect; rst on RUN cycle 5 → next cycle all outputs 0, state IDLE; a fresh start then runs normally.
